recv_control: RTL and testbench
===============================

RECV_CONTROL -- requirements
Module: recv_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1250000, idle cycles in TRACK before loss of sync (10 ms at 125 MHz).
REQ-002 clk125MHz  input  1  sole clock, rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 switches  input  8  segment range select; MAX_SEG = {switches, 8'hFF}.
REQ-005 rx_valid  input  1  one-cycle pulse per received frame descriptor; back-to-back pulses allowed.
REQ-006 crc_ok  input  1  frame FCS good, qualified by rx_valid.
REQ-007 segment_num  input  16  received segment number, qualified by rx_valid.
REQ-008 txid  input  8  received transmitter id, qualified by rx_valid.
REQ-009 aux  input  8  received redundancy copy index; informational, not used for decisions.
REQ-010 synced  output  1  high while in TRACK.
REQ-011 expected_seg  output  16  next in-order segment number.
REQ-012 locked_txid  output  8  txid captured at lock.
REQ-013 good_cnt, lost_cnt, dup_cnt, bad_cnt  output  16 each  saturating event counters.
REQ-014 cycle_done  output  1  one-cycle pulse when segment MAX_SEG is accepted as good.
REQ-015 sync_lost  output  1  one-cycle pulse on TRACK->IDLE timeout.

Function
REQ-016 Two states: IDLE and TRACK.
REQ-017 Frame is "bad" if rx_valid & (!crc_ok | segment_num > MAX_SEG | (TRACK & txid != locked_txid)).
- bad frame: bad_cnt += 1; no other state change.
REQ-018 IDLE, non-bad frame:
- latch MAX_SEG from switches; locked_txid <= txid; prev_seg <= segment_num;
- expected_seg <= inc(segment_num); good_cnt += 1; go to TRACK.
REQ-019 inc(x) = 0 if x == MAX_SEG, else x+1.
REQ-020 TRACK, non-bad frame, segment_num == expected_seg: good_cnt += 1; prev_seg and expected_seg advance.
REQ-021 TRACK, non-bad frame, segment_num == prev_seg: dup_cnt += 1; nothing else changes.
REQ-022 TRACK, any other non-bad frame (gap):
- lost_cnt += D, with D = segment_num - expected_seg if segment_num > expected_seg, else segment_num + MAX_SEG + 1 - expected_seg;
- D computed at 17 bits;
- good_cnt += 1; prev_seg and expected_seg advance as in REQ-020.
REQ-023 switches is sampled only on the IDLE->TRACK transition; changes during TRACK are ignored.
REQ-024 All counters saturate at 16'hFFFF and never wrap.
REQ-025 Latency: all outputs update on the clock edge after the rx_valid cycle; every descriptor in back-to-back pulses is processed.
REQ-026 cycle_done pulses in the cycle after a good (REQ-018/020/022) frame with segment_num == MAX_SEG.
REQ-027 Idle counter:
- cleared on every non-bad frame;
- increments each TRACK cycle without one;
- on reaching TIMEOUT_CYCLES: go to IDLE, pulse sync_lost, counters retained.
- A non-bad frame in the timeout cycle takes priority: it is processed and no timeout occurs.
REQ-028 Counters are cleared only by RST.

Reset
REQ-029 RST (synchronous) forces:
- state IDLE; synced 0; expected_seg 0; locked_txid 0;
- all counters 0; cycle_done 0; sync_lost 0; idle counter 0.
REQ-030 RST asserted mid-operation overrides any rx_valid in the same cycle.

Verification (switches = 8'h5F, so MAX_SEG = 16'h5FFF; txid 8'h3A unless stated)
REQ-031 RST high 2 cycles -> all outputs 0, synced 0.
REQ-032 Segments 0,1,2 -> synced 1 after the first; good_cnt 3; lost_cnt 0; expected_seg 3; locked_txid 8'h3A.
REQ-033 Segments 5, 5 (aux 1), 5 (aux 2), 6 -> good_cnt 2; dup_cnt 2.
REQ-034 Segment gaps:
- 10 then 14 -> lost_cnt 3.
- Separate run: 16'h5FFE then 16'h0001 -> lost_cnt 2 (wrap).
REQ-035 Segments 16'h5FFE, 16'h5FFF, 16'h0000 -> one cycle_done pulse; lost_cnt 0; expected_seg 1.
REQ-036 Error and timeout cases:
- crc_ok 0 -> bad_cnt 1, no other change.
- txid 8'h3B in TRACK -> bad_cnt 1, no other change.
- segment 16'h6000 -> bad_cnt 1, no other change.
- No frames for TIMEOUT_CYCLES (override to 100 in sim) -> sync_lost pulse; synced 0; counters retained.

Source files
------------

// File: rtl/recv_control.sv
// Receive-side segment tracker: locks onto a transmitter, follows in-order segment
// numbers and keeps saturating good/lost/duplicate/bad counters.
module recv_control #(
  parameter int TIMEOUT_CYCLES = 1250000
) (
  input  logic        clk125MHz,
  input  logic        RST,
  input  logic [7:0]  switches,
  input  logic        rx_valid,
  input  logic        crc_ok,
  input  logic [15:0] segment_num,
  input  logic [7:0]  txid,
  input  logic [7:0]  aux,
  output logic        synced,
  output logic [15:0] expected_seg,
  output logic [7:0]  locked_txid,
  output logic [15:0] good_cnt,
  output logic [15:0] lost_cnt,
  output logic [15:0] dup_cnt,
  output logic [15:0] bad_cnt,
  output logic        cycle_done,
  output logic        sync_lost
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  state_t r_state, w_stateNext;

  logic [15:0]   r_maxSeg, w_maxSegNext;
  logic [7:0]    r_lockedTxid, w_lockedTxidNext;
  logic [15:0]   r_prevSeg, w_prevSegNext;
  logic [15:0]   r_expSeg, w_expSegNext;
  logic [15:0]   r_good, w_goodNext;
  logic [15:0]   r_lost, w_lostNext;
  logic [15:0]   r_dup, w_dupNext;
  logic [15:0]   r_bad, w_badNext;
  logic          r_cycleDone, w_cycleDoneNext;
  logic          r_syncLost, w_syncLostNext;
  logic [CW-1:0] r_idleCnt, w_idleCntNext;

  logic [15:0] w_maxSeg;
  logic        w_bad;
  logic        w_frameOk;
  logic        w_accept;
  logic [16:0] w_gap;
  logic        w_unusedAux;

  // aux is a redundancy-copy index carried for debug only.
  assign w_unusedAux = ^aux;

  function automatic logic [15:0] satInc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic [15:0] satAdd(input logic [15:0] x, input logic [16:0] d);
    logic [17:0] s;
    s = {2'b00, x} + {1'b0, d};
    return (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] segInc(input logic [15:0] x, input logic [15:0] maxSeg);
    return (x == maxSeg) ? 16'h0000 : x + 16'd1;
  endfunction

  // Range comes live from the switches until lock, then is frozen for the session.
  assign w_maxSeg = (r_state == TRACK) ? r_maxSeg : {switches, 8'hFF};

  assign w_bad = rx_valid & (~crc_ok | (segment_num > w_maxSeg) |
                             ((r_state == TRACK) & (txid != r_lockedTxid)));
  assign w_frameOk = rx_valid & ~w_bad;

  assign w_gap = (segment_num > r_expSeg) ?
                 ({1'b0, segment_num} - {1'b0, r_expSeg}) :
                 ({1'b0, segment_num} + {1'b0, r_maxSeg} + 17'd1 - {1'b0, r_expSeg});

  // Anything not in-order and not a repeat of the previous segment is a gap,
  // but still an accepted frame that resynchronises expected_seg.
  assign w_accept = w_frameOk & ((r_state == IDLE) | (segment_num == r_expSeg) |
                                 (segment_num != r_prevSeg));

  always_comb begin
    w_stateNext      = r_state;
    w_maxSegNext     = r_maxSeg;
    w_lockedTxidNext = r_lockedTxid;
    w_prevSegNext    = r_prevSeg;
    w_expSegNext     = r_expSeg;
    w_goodNext       = r_good;
    w_lostNext       = r_lost;
    w_dupNext        = r_dup;
    w_badNext        = r_bad;
    w_cycleDoneNext  = 1'b0;
    w_syncLostNext   = 1'b0;
    w_idleCntNext    = r_idleCnt;

    if (w_bad) begin
      w_badNext = satInc(r_bad);
    end

    if (w_frameOk) begin
      w_idleCntNext = '0;
      if (r_state == IDLE) begin
        w_stateNext      = TRACK;
        w_maxSegNext     = w_maxSeg;
        w_lockedTxidNext = txid;
      end else if ((segment_num != r_expSeg) && (segment_num == r_prevSeg)) begin
        w_dupNext = satInc(r_dup);
      end else if (segment_num != r_expSeg) begin
        w_lostNext = satAdd(r_lost, w_gap);
      end
    end

    if (w_accept) begin
      w_prevSegNext   = segment_num;
      w_expSegNext    = segInc(segment_num, w_maxSeg);
      w_goodNext      = satInc(r_good);
      w_cycleDoneNext = (segment_num == w_maxSeg);
    end

    // A valid frame in the final idle cycle wins over the timeout.
    if ((r_state == TRACK) && !w_frameOk) begin
      if (r_idleCnt == IDLE_LAST) begin
        w_stateNext    = IDLE;
        w_syncLostNext = 1'b1;
        w_idleCntNext  = '0;
      end else begin
        w_idleCntNext = r_idleCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (RST) begin
      r_state      <= IDLE;
      r_maxSeg     <= 16'h0000;
      r_lockedTxid <= 8'h00;
      r_prevSeg    <= 16'h0000;
      r_expSeg     <= 16'h0000;
      r_good       <= 16'h0000;
      r_lost       <= 16'h0000;
      r_dup        <= 16'h0000;
      r_bad        <= 16'h0000;
      r_cycleDone  <= 1'b0;
      r_syncLost   <= 1'b0;
      r_idleCnt    <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_maxSeg     <= w_maxSegNext;
      r_lockedTxid <= w_lockedTxidNext;
      r_prevSeg    <= w_prevSegNext;
      r_expSeg     <= w_expSegNext;
      r_good       <= w_goodNext;
      r_lost       <= w_lostNext;
      r_dup        <= w_dupNext;
      r_bad        <= w_badNext;
      r_cycleDone  <= w_cycleDoneNext;
      r_syncLost   <= w_syncLostNext;
      r_idleCnt    <= w_idleCntNext;
    end
  end

  assign synced       = (r_state == TRACK);
  assign expected_seg = r_expSeg;
  assign locked_txid  = r_lockedTxid;
  assign good_cnt     = r_good;
  assign lost_cnt     = r_lost;
  assign dup_cnt      = r_dup;
  assign bad_cnt      = r_bad;
  assign cycle_done   = r_cycleDone;
  assign sync_lost    = r_syncLost;

endmodule

// File: tb/tb_recv_control.sv
// Directed bench for recv_control: lock, in-order, duplicates, gaps, wrap,
// bad frames, frozen segment range and idle timeout.
module tb_recv_control;

  logic        clk125MHz;
  logic        RST;
  logic [7:0]  switches;
  logic        rx_valid;
  logic        crc_ok;
  logic [15:0] segment_num;
  logic [7:0]  txid;
  logic [7:0]  aux;
  logic        synced;
  logic [15:0] expected_seg;
  logic [7:0]  locked_txid;
  logic [15:0] good_cnt, lost_cnt, dup_cnt, bad_cnt;
  logic        cycle_done;
  logic        sync_lost;

  int checks = 0;
  int errors = 0;

  recv_control #(.TIMEOUT_CYCLES(100)) dut (
    .clk125MHz   (clk125MHz),
    .RST         (RST),
    .switches    (switches),
    .rx_valid    (rx_valid),
    .crc_ok      (crc_ok),
    .segment_num (segment_num),
    .txid        (txid),
    .aux         (aux),
    .synced      (synced),
    .expected_seg(expected_seg),
    .locked_txid (locked_txid),
    .good_cnt    (good_cnt),
    .lost_cnt    (lost_cnt),
    .dup_cnt     (dup_cnt),
    .bad_cnt     (bad_cnt),
    .cycle_done  (cycle_done),
    .sync_lost   (sync_lost)
  );

  initial clk125MHz = 1'b0;
  always #4 clk125MHz = ~clk125MHz;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one descriptor for one cycle and returns at the next falling edge,
  // leaving rx_valid high so consecutive calls are back-to-back.
  task automatic applyStimulus(input logic [15:0] seg, input logic [7:0] tx,
                               input logic crc, input logic [7:0] a);
    rx_valid    = 1'b1;
    segment_num = seg;
    txid        = tx;
    crc_ok      = crc;
    aux         = a;
    @(negedge clk125MHz);
  endtask

  task automatic idleCycles(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk125MHz);
  endtask

  task automatic doReset();
    RST         = 1'b1;
    rx_valid    = 1'b1;
    crc_ok      = 1'b1;
    segment_num = 16'h0000;
    txid        = 8'h3A;
    repeat (2) @(negedge clk125MHz);
    RST      = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    RST         = 1'b1;
    switches    = 8'h5F;
    rx_valid    = 1'b0;
    crc_ok      = 1'b1;
    segment_num = 16'h0000;
    txid        = 8'h3A;
    aux         = 8'h00;
    @(negedge clk125MHz);

    // Reset with a valid frame present must still leave everything cleared.
    doReset();
    checkOutput("rst_synced", 32'(synced), 32'd0);
    checkOutput("rst_expected", 32'(expected_seg), 32'd0);
    checkOutput("rst_txid", 32'(locked_txid), 32'd0);
    checkOutput("rst_counters", {good_cnt, lost_cnt} | {dup_cnt, bad_cnt}, 32'd0);
    checkOutput("rst_pulses", {30'd0, cycle_done, sync_lost}, 32'd0);

    // In-order run, back-to-back.
    applyStimulus(16'd0, 8'h3A, 1'b1, 8'd0);
    checkOutput("lock_synced", 32'(synced), 32'd1);
    applyStimulus(16'd1, 8'h3A, 1'b1, 8'd0);
    applyStimulus(16'd2, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("inorder_good", 32'(good_cnt), 32'd3);
    checkOutput("inorder_lost", 32'(lost_cnt), 32'd0);
    checkOutput("inorder_expected", 32'(expected_seg), 32'd3);
    checkOutput("inorder_txid", 32'(locked_txid), 32'h3A);

    // Duplicates.
    doReset();
    applyStimulus(16'd5, 8'h3A, 1'b1, 8'd0);
    applyStimulus(16'd5, 8'h3A, 1'b1, 8'd1);
    applyStimulus(16'd5, 8'h3A, 1'b1, 8'd2);
    applyStimulus(16'd6, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("dup_good", 32'(good_cnt), 32'd2);
    checkOutput("dup_dup", 32'(dup_cnt), 32'd2);
    checkOutput("dup_expected", 32'(expected_seg), 32'd7);

    // Forward gap.
    doReset();
    applyStimulus(16'd10, 8'h3A, 1'b1, 8'd0);
    applyStimulus(16'd14, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("gap_lost", 32'(lost_cnt), 32'd3);
    checkOutput("gap_good", 32'(good_cnt), 32'd2);
    checkOutput("gap_expected", 32'(expected_seg), 32'd15);

    // Gap across the wrap point.
    doReset();
    applyStimulus(16'h5FFE, 8'h3A, 1'b1, 8'd0);
    applyStimulus(16'h0001, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("wrapgap_lost", 32'(lost_cnt), 32'd2);
    checkOutput("wrapgap_expected", 32'(expected_seg), 32'd2);

    // Wrap with cycle_done; switches change after lock must be ignored.
    doReset();
    applyStimulus(16'h5FFE, 8'h3A, 1'b1, 8'd0);
    checkOutput("wrap_cd0", 32'(cycle_done), 32'd0);
    switches = 8'h10;
    applyStimulus(16'h5FFF, 8'h3A, 1'b1, 8'd0);
    checkOutput("wrap_cd1", 32'(cycle_done), 32'd1);
    applyStimulus(16'h0000, 8'h3A, 1'b1, 8'd0);
    checkOutput("wrap_cd2", 32'(cycle_done), 32'd0);
    idleCycles(1);
    checkOutput("wrap_cd3", 32'(cycle_done), 32'd0);
    checkOutput("wrap_lost", 32'(lost_cnt), 32'd0);
    checkOutput("wrap_bad", 32'(bad_cnt), 32'd0);
    checkOutput("wrap_expected", 32'(expected_seg), 32'd1);
    checkOutput("wrap_good", 32'(good_cnt), 32'd3);
    switches = 8'h5F;

    // Bad frames: CRC, foreign txid, out-of-range segment.
    doReset();
    applyStimulus(16'd0, 8'h3A, 1'b1, 8'd0);
    applyStimulus(16'd1, 8'h3A, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("crc_bad", 32'(bad_cnt), 32'd1);
    checkOutput("crc_good", 32'(good_cnt), 32'd1);
    checkOutput("crc_expected", 32'(expected_seg), 32'd1);
    applyStimulus(16'd1, 8'h3B, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("txid_bad", 32'(bad_cnt), 32'd2);
    checkOutput("txid_state", {good_cnt, expected_seg}, {16'd1, 16'd1});
    checkOutput("txid_locked", 32'(locked_txid), 32'h3A);
    applyStimulus(16'h6000, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("range_bad", 32'(bad_cnt), 32'd3);
    checkOutput("range_state", {good_cnt, expected_seg}, {16'd1, 16'd1});
    checkOutput("range_lost", 32'(lost_cnt), 32'd0);
    applyStimulus(16'd1, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("after_bad_good", 32'(good_cnt), 32'd2);

    // Out-of-range segment in IDLE is bad and does not lock.
    doReset();
    applyStimulus(16'h6000, 8'h3A, 1'b1, 8'd0);
    idleCycles(1);
    checkOutput("idle_range_synced", 32'(synced), 32'd0);
    checkOutput("idle_range_bad", 32'(bad_cnt), 32'd1);

    // Idle timeout with TIMEOUT_CYCLES = 100.
    doReset();
    applyStimulus(16'd0, 8'h3A, 1'b1, 8'd0);
    applyStimulus(16'd3, 8'h3A, 1'b1, 8'd0);
    idleCycles(99);
    checkOutput("to_pre_synced", 32'(synced), 32'd1);
    checkOutput("to_pre_pulse", 32'(sync_lost), 32'd0);
    idleCycles(1);
    checkOutput("to_pulse", 32'(sync_lost), 32'd1);
    checkOutput("to_synced", 32'(synced), 32'd0);
    checkOutput("to_retained", {good_cnt, lost_cnt}, {16'd2, 16'd2});
    idleCycles(1);
    checkOutput("to_pulse_end", 32'(sync_lost), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
